// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_NUM_REGISTERS  = 32;
  localparam int unsigned DEF_NUM_READ_PORTS = 2;
  localparam int unsigned DEF_BYPASS         = 1;
  localparam int unsigned DEF_IDX_W          = $clog2(DEF_NUM_REGISTERS);

  // Register 0 reads as zero and can never be reserved.
  localparam int unsigned ZERO_REG = 0;

  typedef logic [DEF_IDX_W-1:0] idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reservation handshake, write-back clear,
// live busy count and sticky error on write-back to an idle register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGISTERS = DEF_NUM_REGISTERS,
  localparam int unsigned IDX_W = $clog2(NUM_REGISTERS),
  localparam int unsigned CNT_W = IDX_W + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rsv_valid,
  input  logic [IDX_W-1:0]         rsv_addr,
  output logic                     rsv_ready,
  input  logic                     wb_valid,
  input  logic [IDX_W-1:0]         wb_addr,
  output logic [NUM_REGISTERS-1:0] busy,
  output logic [CNT_W-1:0]         busy_count,
  output logic                     err
);

  logic [NUM_REGISTERS-1:0] r_busy;
  logic [CNT_W-1:0]         r_busy_count;
  logic                     r_err;

  logic w_wb_nz;
  logic w_rsv_nz;
  logic w_same;
  logic w_set;
  logic w_clr;
  logic w_inc;
  logic w_dec;
  logic w_err_set;

  always_comb begin
    w_wb_nz   = wb_valid && (wb_addr != IDX_W'(ZERO_REG));
    w_rsv_nz  = rsv_addr != IDX_W'(ZERO_REG);
    w_same    = wb_valid && (wb_addr == rsv_addr);
    rsv_ready = !r_busy[rsv_addr] || w_same;
    w_set     = rsv_valid && rsv_ready && w_rsv_nz;
    w_clr     = w_wb_nz && r_busy[wb_addr];
    w_err_set = w_wb_nz && !r_busy[wb_addr];
    // Count tracks real bit transitions; a reserve that re-arms a register
    // being cleared in the same cycle leaves the population unchanged.
    w_inc     = w_set && !r_busy[rsv_addr];
    w_dec     = w_clr && !(w_set && w_same);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= '0;
      r_busy_count <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_clr) r_busy[wb_addr] <= 1'b0;
      if (w_set) r_busy[rsv_addr] <= 1'b1;
      r_busy_count <= r_busy_count + CNT_W'(w_inc) - CNT_W'(w_dec);
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign busy       = r_busy;
  assign busy_count = r_busy_count;
  assign err        = r_err;

endmodule

// File: rtl/scoreboarded_registers.sv
// Register file with combinational read ports, optional write-back bypass
// and a busy scoreboard that gates operand readiness.
module scoreboarded_registers
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REGISTERS  = DEF_NUM_REGISTERS,
  parameter int unsigned NUM_READ_PORTS = DEF_NUM_READ_PORTS,
  parameter int unsigned BYPASS         = DEF_BYPASS,
  localparam int unsigned IDX_W = $clog2(NUM_REGISTERS)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_READ_PORTS-1:0][IDX_W-1:0]      rd_addr,
  output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ_PORTS-1:0]                 rd_ready,
  input  logic                                      rsv_valid,
  input  logic [IDX_W-1:0]                          rsv_addr,
  output logic                                      rsv_ready,
  input  logic                                      wb_valid,
  input  logic [IDX_W-1:0]                          wb_addr,
  input  logic [DATA_WIDTH-1:0]                     wb_data,
  output logic [IDX_W:0]                            busy_count,
  output logic                                      err
);

  logic [DATA_WIDTH-1:0]    r_regs [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0] w_busy;
  logic                     w_wb_nz;

  assign w_wb_nz = wb_valid && (wb_addr != IDX_W'(ZERO_REG));

  regfile_scoreboard #(
    .NUM_REGISTERS(NUM_REGISTERS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .busy      (w_busy),
    .busy_count(busy_count),
    .err       (err)
  );

  // Data array; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGISTERS); i++) r_regs[i] <= '0;
    end else if (w_wb_nz) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Read muxes with optional same-cycle forwarding of the write-back value.
  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
      rd_data[p]  = r_regs[rd_addr[p]];
      rd_ready[p] = !w_busy[rd_addr[p]];
      if ((BYPASS != 0) && w_wb_nz && (wb_addr == rd_addr[p])) begin
        rd_data[p]  = wb_data;
        rd_ready[p] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scoreboarded_registers.sv
// Directed bench for scoreboarded_registers: a bypassing instance plus a
// non-bypassing instance driven by the same stimulus.
module tb_scoreboarded_registers;

  logic             clk;
  logic             rst_n;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic [1:0]       rd_ready;
  logic             rsv_valid;
  logic [4:0]       rsv_addr;
  logic             rsv_ready;
  logic             wb_valid;
  logic [4:0]       wb_addr;
  logic [31:0]      wb_data;
  logic [5:0]       busy_count;
  logic             err;

  logic [1:0][31:0] nb_rd_data;
  logic [1:0]       nb_rd_ready;
  logic             nb_rsv_ready;
  logic [5:0]       nb_busy_count;
  logic             nb_err;

  int checks   = 0;
  int failures = 0;

  scoreboarded_registers #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_ready(rd_ready), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rsv_ready(rsv_ready), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .busy_count(busy_count), .err(err)
  );

  scoreboarded_registers #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(nb_rd_data),
    .rd_ready(nb_rd_ready), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rsv_ready(nb_rsv_ready), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .busy_count(nb_busy_count), .err(nb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    rd_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy_count !== 6'd0) begin failures++; $display("FAIL reset_busy_count got=%0d exp=0", busy_count); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd_addr[0] = 5'(a);
      rd_addr[1] = 5'(31 - a);
      #1;
      checks++; if (rd_data[0] !== 32'h0 || rd_data[1] !== 32'h0) begin failures++; $display("FAIL reset_rd_data idx=%0d got=%h/%h exp=0/0", a, rd_data[0], rd_data[1]); end
      checks++; if (rd_ready !== 2'b11) begin failures++; $display("FAIL reset_rd_ready idx=%0d got=%b exp=11", a, rd_ready); end
    end
    @(negedge clk); #1;
    checks++; if (busy_count !== 6'd0 || err !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%0d/%b exp=0/0", busy_count, err); end
  endtask

  task automatic test_reserve_wb();
    @(negedge clk);
    rd_addr[0] = 5'd5;
    rsv_valid = 1'b1; rsv_addr = 5'd5;
    #1;
    checks++; if (rsv_ready !== 1'b1) begin failures++; $display("FAIL rsv5_ready got=%b exp=1", rsv_ready); end
    checks++; if (rd_ready[0] !== 1'b1) begin failures++; $display("FAIL r5_ready_before got=%b exp=1", rd_ready[0]); end
    @(negedge clk);
    rsv_valid = 1'b0;
    #1;
    checks++; if (busy_count !== 6'd1) begin failures++; $display("FAIL rsv5_count got=%0d exp=1", busy_count); end
    checks++; if (rd_ready[0] !== 1'b0) begin failures++; $display("FAIL r5_busy_ready got=%b exp=0", rd_ready[0]); end
    @(negedge clk);
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    checks++; if (rd_data[0] !== 32'hDEADBEEF || rd_ready[0] !== 1'b1) begin failures++; $display("FAIL r5_bypass got=%h/%b exp=deadbeef/1", rd_data[0], rd_ready[0]); end
    checks++; if (nb_rd_data[0] !== 32'h0 || nb_rd_ready[0] !== 1'b0) begin failures++; $display("FAIL r5_nobypass got=%h/%b exp=0/0", nb_rd_data[0], nb_rd_ready[0]); end
    checks++; if (busy_count !== 6'd1) begin failures++; $display("FAIL r5_count_wbcycle got=%0d exp=1", busy_count); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (busy_count !== 6'd0) begin failures++; $display("FAIL r5_count_after got=%0d exp=0", busy_count); end
    checks++; if (rd_data[0] !== 32'hDEADBEEF || rd_ready[0] !== 1'b1) begin failures++; $display("FAIL r5_after got=%h/%b exp=deadbeef/1", rd_data[0], rd_ready[0]); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL r5_err got=%b exp=0", err); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rd_addr[1] = 5'd7;
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    #1;
    checks++; if (rsv_ready !== 1'b1) begin failures++; $display("FAIL r7_first_ready got=%b exp=1", rsv_ready); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++; if (rsv_ready !== 1'b0) begin failures++; $display("FAIL r7_stall cyc=%0d got=%b exp=0", c, rsv_ready); end
      checks++; if (busy_count !== 6'd1) begin failures++; $display("FAIL r7_stall_count cyc=%0d got=%0d exp=1", c, busy_count); end
    end
    @(negedge clk);
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_0077;
    #1;
    checks++; if (rsv_ready !== 1'b1) begin failures++; $display("FAIL r7_accept_on_wb got=%b exp=1", rsv_ready); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (busy_count !== 6'd1) begin failures++; $display("FAIL r7_count_kept got=%0d exp=1", busy_count); end
    checks++; if (rd_ready[1] !== 1'b0 || rd_data[1] !== 32'h77) begin failures++; $display("FAIL r7_rebusy got=%b/%h exp=0/77", rd_ready[1], rd_data[1]); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL r7_err got=%b exp=0", err); end
    @(negedge clk);
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_0078;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (busy_count !== 6'd0 || err !== 1'b0) begin failures++; $display("FAIL r7_release got=%0d/%b exp=0/0", busy_count, err); end
  endtask

  task automatic test_err_sticky();
    @(negedge clk);
    rd_addr[1] = 5'd9;
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h1234;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL r9_err got=%b exp=1", err); end
    checks++; if (rd_data[1] !== 32'h1234 || nb_rd_data[1] !== 32'h1234) begin failures++; $display("FAIL r9_data got=%h/%h exp=1234", rd_data[1], nb_rd_data[1]); end
    checks++; if (busy_count !== 6'd0) begin failures++; $display("FAIL r9_count got=%0d exp=0", busy_count); end
    @(negedge clk);
    rd_addr[0] = 5'd0;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    checks++; if (rd_data[0] !== 32'h0 || rd_ready[0] !== 1'b1) begin failures++; $display("FAIL r0_wb_cycle got=%h/%b exp=0/1", rd_data[0], rd_ready[0]); end
    checks++; if (rsv_ready !== 1'b1) begin failures++; $display("FAIL r0_rsv_ready got=%b exp=1", rsv_ready); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (rd_data[0] !== 32'h0) begin failures++; $display("FAIL r0_after got=%h exp=0", rd_data[0]); end
    checks++; if (err !== 1'b1 || nb_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b/%b exp=1/1", err, nb_err); end
  endtask

  task automatic test_fill_reset();
    for (int k = 1; k < 32; k++) begin
      @(negedge clk);
      rsv_valid = 1'b1; rsv_addr = 5'(k);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (busy_count !== 6'd31) begin failures++; $display("FAIL fill_count got=%0d exp=31", busy_count); end
    for (int a = 1; a < 32; a++) begin
      rd_addr[0] = 5'(a);
      #1;
      checks++; if (rd_ready[0] !== 1'b0) begin failures++; $display("FAIL fill_ready idx=%0d got=%b exp=0", a, rd_ready[0]); end
    end
    @(negedge clk);
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd9;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy_count !== 6'd0 || err !== 1'b0) begin failures++; $display("FAIL async_reset_state got=%0d/%b exp=0/0", busy_count, err); end
    checks++; if (rd_data[0] !== 32'h0 || rd_data[1] !== 32'h0) begin failures++; $display("FAIL async_reset_data got=%h/%h exp=0/0", rd_data[0], rd_data[1]); end
    checks++; if (rd_ready !== 2'b11) begin failures++; $display("FAIL async_reset_ready got=%b exp=11", rd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_no_bypass();
    @(negedge clk);
    rd_addr[0] = 5'd3;
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5A5A5;
    #1;
    checks++; if (nb_rd_data[0] !== 32'h0 || nb_rd_ready[0] !== 1'b1) begin failures++; $display("FAIL nb_r3_same got=%h/%b exp=0/1", nb_rd_data[0], nb_rd_ready[0]); end
    checks++; if (rd_data[0] !== 32'hA5A5A5A5) begin failures++; $display("FAIL byp_r3_same got=%h exp=a5a5a5a5", rd_data[0]); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (nb_rd_data[0] !== 32'hA5A5A5A5) begin failures++; $display("FAIL nb_r3_next got=%h exp=a5a5a5a5", nb_rd_data[0]); end
    checks++; if (nb_err !== 1'b1 || nb_busy_count !== 6'd0) begin failures++; $display("FAIL nb_r3_state got=%b/%0d exp=1/0", nb_err, nb_busy_count); end
  endtask

  initial begin
    test_reset();
    test_reserve_wb();
    test_back_to_back();
    test_err_sticky();
    test_fill_reset();
    test_no_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scoreboarded_registers.md
# scoreboarded_registers

Parametrised general-purpose register file with N combinational read ports, one write-back port and a per-register busy scoreboard. Sits between decode/issue and write-back: issue reserves a destination register before dispatch, write-back clears the reservation when it writes the result, and each read port reports whether its operand is currently valid. Register 0 is hard-wired to zero and is never busy.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- NUM_REGISTERS, 32, register count (power of two, at least 2); IDX_W = $clog2(NUM_REGISTERS)
- NUM_READ_PORTS, 2, number of independent read ports (at least 1)
- BYPASS, 1, 1 = same-cycle write-back forwarding to read ports; 0 = write visible next cycle only

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  [NUM_READ_PORTS][IDX_W]  read register index per port
- rd_data  out  [NUM_READ_PORTS][DATA_WIDTH]  read data per port
- rd_ready  out  [NUM_READ_PORTS]  operand valid (register not busy, or forwarded)
- rsv_valid  in  1  request to reserve rsv_addr as a pending destination
- rsv_addr  in  IDX_W  register to reserve
- rsv_ready  out  1  reservation accepted this cycle (handshake completes when rsv_valid && rsv_ready)
- wb_valid  in  1  write-back strobe (always accepted)
- wb_addr  in  IDX_W  write-back register index
- wb_data  in  DATA_WIDTH  write-back data
- busy_count  out  IDX_W+1  number of registers currently busy
- err  out  1  sticky: write-back to a register that was not busy

## Operation
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0, busy_count 0, err 0. Reads during reset return 0 with rd_ready 1.
- Read: rd_data[p] = reg[rd_addr[p]]; rd_ready[p] = !busy[rd_addr[p]]. Index 0 always returns 0 with ready 1.
- BYPASS=1: if wb_valid && wb_addr == rd_addr[p] && wb_addr != 0, then rd_data[p] = wb_data and rd_ready[p] = 1 in the same cycle.
- Reserve: rsv_ready = !busy[rsv_addr] || (wb_valid && wb_addr == rsv_addr). On handshake, set busy[rsv_addr]. Reserving index 0 is always accepted and has no effect.
- Write-back: on wb_valid with wb_addr != 0, write reg[wb_addr] <= wb_data and clear busy[wb_addr]. If busy[wb_addr] was 0, set err. Writes to index 0 are discarded and do not set err.
- Simultaneous reserve and write-back to the same nonzero register: the data is written, busy ends set (the reservation wins), and err is not set if the register was busy.
- busy_count: +1 on an effective set, -1 on an effective clear, net 0 when both occur or when they target the same register. It never wraps, because at most NUM_REGISTERS-1 registers can be busy.
- err clears only on reset.

## Timing
- Reads are combinational with zero latency. With BYPASS=0, written data appears on rd_data the cycle after wb_valid.
- rsv_ready is combinational from rsv_addr, busy and the write-back inputs. It does not depend on rsv_valid.
- busy, busy_count and err update on the posedge following the event.
- Back-to-back reserve of the same register: the second request sees busy=1 and stalls (rsv_ready=0) until a write-back to that register arrives. It is accepted in that write-back cycle.
- Reset asserted mid-operation clears all state immediately. On the first posedge after rst_n rises, inputs are sampled normally.

## Structure
- Package regfile_pkg: ZERO_REG = 0 constant, default-parameter localparams, and the idx_t typedef for the default IDX_W.
- Sub-module regfile_scoreboard: busy bit vector, busy_count and err, with the reserve/clear logic and rsv_ready. The top level holds the data array, the read muxes and the bypass.

## Test plan
- Reset, then read all 32 indices on both ports -> rd_data 0, rd_ready 1, busy_count 0, err 0.
- Reserve r5, then write-back r5=0xDEADBEEF two cycles later -> rd_ready for r5 is 0 until write-back; with BYPASS=1 rd_data=0xDEADBEEF and ready=1 in the write-back cycle; busy_count goes 0→1→0.
- Reserve r7 twice consecutively -> second rsv_ready=0; write-back r7 arrives -> second reservation accepted that cycle; busy_count stays 1 and busy[r7] stays set.
- Write-back r9=0x1234 while r9 is not busy -> reg[r9]=0x1234 next cycle, err=1 and sticky; write-back to r0 -> r0 still reads 0, err unaffected.
- Reserve r1..r31 one per cycle -> busy_count=31, all rd_ready low; assert rst_n=0 mid-sequence -> busy_count 0 and all data 0 immediately.
- BYPASS=0 build, write-back r3=0xA5A5A5A5 while reading r3 -> old value in that cycle, 0xA5A5A5A5 on the next.
